seq_signed_divider: RTL and testbench

Sequential 8-bit signed divider: restoring shift-and-subtract, one quotient bit per clock. It is the inverse companion of the team's sequential Booth multiplier, and shares its operand widths and start/done style so the two can sit side by side in the arithmetic unit. The block contains its own control FSM, iteration counter, magnitude/sign logic and result registers. It signals divide-by-zero and the single signed-overflow case.

---
 rtl/seq_signed_divider.sv | 177 +++++++++++++++++
 tb/tb_seq_signed_divider.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// Sequential 8-bit signed divider: restoring shift-and-subtract on magnitudes,
// one quotient bit per clock, followed by a sign-correction cycle.
module seq_signed_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       div_by_zero,
    output logic       overflow
);

    // Handshake: start is sampled only in IDLE; busy is high from the accepting
    // edge until the edge that raises done; done is a one-cycle pulse and the
    // results/flags stay valid from then until the next accepting edge.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ITER    = 2'd1,
        S_CORRECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [8:0]  r_q, r_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  dvs_mag_q, dvs_mag_d;
    logic [7:0]  dividend_q, dividend_d;
    logic [7:0]  divisor_q, divisor_d;
    logic        dvd_neg_q, dvd_neg_d;
    logic        dvs_neg_q, dvs_neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        div_by_zero_q, div_by_zero_d;
    logic        overflow_q, overflow_d;

    logic [8:0]  r_shift;
    logic [8:0]  trial;
    logic [7:0]  q_final;
    logic [7:0]  rem_final;

    function automatic logic [7:0] mag8(input logic [7:0] x);
        return x[7] ? (~x + 8'd1) : x;
    endfunction

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        r_d           = r_q;
        q_d           = q_q;
        dvs_mag_d     = dvs_mag_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        dvd_neg_d     = dvd_neg_q;
        dvs_neg_d     = dvs_neg_q;
        busy_d        = busy_q;
        done_d        = done_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        // R stays below the divisor magnitude (<= 128), so 9 bits hold the
        // shifted value and trial[8] is a valid sign bit.
        r_shift   = {r_q[7:0], q_q[7]};
        trial     = r_shift - {1'b0, dvs_mag_q};
        q_final   = (dvd_neg_q ^ dvs_neg_q) ? (~q_q + 8'd1) : q_q;
        rem_final = dvd_neg_q ? (~r_q[7:0] + 8'd1) : r_q[7:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dividend_d    = dividend;
                    divisor_d     = divisor;
                    dvd_neg_d     = dividend[7];
                    dvs_neg_d     = divisor[7];
                    dvs_mag_d     = mag8(divisor);
                    q_d           = mag8(dividend);
                    r_d           = 9'd0;
                    count_d       = 4'd8;
                    busy_d        = 1'b1;
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b0;
                    state_d       = (divisor == 8'd0) ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (trial[8]) begin
                    r_d = r_shift;
                    q_d = {q_q[6:0], 1'b0};
                end else begin
                    r_d = trial;
                    q_d = {q_q[6:0], 1'b1};
                end
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = S_CORRECT;
                end
            end
            S_CORRECT: begin
                quotient_d  = q_final;
                remainder_d = rem_final;
                overflow_d  = (dividend_q == 8'h80) && (divisor_q == 8'hFF);
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_DONE;
            end
            S_DONE: begin
                // Divide-by-zero arrives here with done still low and spends
                // one extra cycle publishing its fixed result.
                if (done_q) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    quotient_d    = 8'hFF;
                    remainder_d   = dividend_q;
                    div_by_zero_d = 1'b1;
                    done_d        = 1'b1;
                    busy_d        = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            count_q       <= 4'd0;
            r_q           <= 9'd0;
            q_q           <= 8'd0;
            dvs_mag_q     <= 8'd0;
            dividend_q    <= 8'd0;
            divisor_q     <= 8'd0;
            dvd_neg_q     <= 1'b0;
            dvs_neg_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= 8'd0;
            remainder_q   <= 8'd0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            r_q           <= r_d;
            q_q           <= q_d;
            dvs_mag_q     <= dvs_mag_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            dvd_neg_q     <= dvd_neg_d;
            dvs_neg_q     <= dvs_neg_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: hand-computed vectors, latency,
// busy/done timing, reset abort and start-handling cases.
module tb_seq_signed_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    int checks;
    int failures;

    seq_signed_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive operands and start, let the accepting edge pass, then scramble
    // the operand inputs. Returns at the falling edge after the accept edge.
    task automatic start_op(input string tag, input logic [7:0] dvd, input logic [7:0] dvs);
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom_range(0, 255));
        divisor  = 8'($urandom_range(0, 255));
        @(negedge clk);
        chk({tag, "_busy_accept"}, busy, 1'b1);
        chk({tag, "_done_accept"}, done, 1'b0);
    endtask

    // Count rising edges until done is seen; also count cycles where busy
    // was low before done.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_idle);
        int n;
        int idle;
        n    = 0;
        idle = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done === 1'b1) break;
            if (busy !== 1'b1) idle++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_idle_cycles"}, idle, exp_idle);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
    endtask

    task automatic chk_result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                              input logic edz, input logic eov);
        chk({tag, "_quotient"}, quotient, eq);
        chk({tag, "_remainder"}, remainder, er);
        chk({tag, "_div_by_zero"}, div_by_zero, edz);
        chk({tag, "_overflow"}, overflow, eov);
    endtask

    task automatic run_op(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov, input int lat);
        start_op(tag, dvd, dvs);
        wait_done(tag, lat, 0);
        chk_result(tag, eq, er, edz, eov);
        @(negedge clk);
        chk({tag, "_done_pulse_width"}, done, 1'b0);
        chk({tag, "_quotient_hold"}, quotient, eq);
    endtask

    initial begin
        int done_seen;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk_result("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Basic and sign combinations
        run_op("d100_7",   8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9);
        run_op("dm100_7",  8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 9);
        run_op("d100_m7",  8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 9);
        run_op("dm100_m7", 8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 9);
        run_op("d5_9",     8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 1'b0, 9);

        // Divide by zero, then a normal op clears the flag
        run_op("d7_0",     8'h07, 8'h00, 8'hFF, 8'h07, 1'b1, 1'b0, 1);
        run_op("clr_dz",   8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9);

        // Overflow and extremes
        run_op("dm128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 9);
        run_op("dm128_1",  8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 9);
        run_op("d127_127", 8'h7F, 8'h7F, 8'h01, 8'h00, 1'b0, 1'b0, 9);
        run_op("dm128_7",  8'h80, 8'h07, 8'hEE, 8'hFE, 1'b0, 1'b0, 9);

        // Reset during the 4th ITER cycle
        start_op("rst_mid", 8'h64, 8'h07);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk_result("rst_mid", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("rst_mid_no_done", done_seen, 0);
        run_op("after_rst", 8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9);

        // start pulsed while busy with other operands is ignored
        start_op("pulse", 8'h64, 8'h07);
        @(posedge clk);
        @(negedge clk);
        dividend = 8'h32;
        divisor  = 8'h03;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        wait_done("pulse", 7, 0);
        chk_result("pulse", 8'h0E, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        done_seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("pulse_no_second_op", done_seen, 0);

        // start held high across the done cycle
        @(negedge clk);
        dividend = 8'h64;
        divisor  = 8'h07;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold1_busy_accept", busy, 1'b1);
        wait_done("hold1", 9, 0);
        chk_result("hold1", 8'h0E, 8'h02, 1'b0, 1'b0);
        dividend = 8'h9C;
        divisor  = 8'hF9;
        wait_done("hold2", 11, 1);
        start = 1'b0;
        chk_result("hold2", 8'h0E, 8'hFE, 1'b0, 1'b0);
        @(negedge clk);
        chk("hold2_done_pulse_width", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
